// File: rtl/decode_scoreboard_dispatch_pkg.sv
// decode_scoreboard_dispatch_pkg: shared defaults, typedefs and FU constants for the dispatch scoreboard
package decode_scoreboard_dispatch_pkg;
  localparam int NUM_REGS_DEF = 32;
  localparam int ROB_ENTRIES_DEF = 8;
  localparam int NUM_FU_DEF = 2;
  localparam int WB_PORTS_DEF = 1;
  typedef logic [$clog2(ROB_ENTRIES_DEF)-1:0] rob_id_t;
  typedef logic [$clog2(NUM_REGS_DEF)-1:0] reg_addr_t;
  typedef logic [0:0] fu_sel_t;
  typedef enum logic [0:0] {FU_ALU = 1'b0, FU_MUL = 1'b1} fu_e;
  typedef struct packed {
    rob_id_t id;
    rob_id_t ticket1;
    rob_id_t ticket2;
    logic    blocked1;
    logic    blocked2;
  } disp_req_t;
  function automatic int fu_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/scoreboard_regtable.sv
// scoreboard_regtable: per-register blocked bits and producer tickets with multi-port writeback clear
module scoreboard_regtable #(
  parameter int NUM_REGS = 32,
  parameter int ROB_ENTRIES = 8,
  parameter int WB_PORTS = 1,
  localparam int RA_W = $clog2(NUM_REGS),
  localparam int ID_W = $clog2(ROB_ENTRIES)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     alloc_en,
  input  logic [RA_W-1:0]          alloc_dest,
  input  logic [ID_W-1:0]          alloc_id,
  input  logic [WB_PORTS-1:0]      wb_valid,
  input  logic [WB_PORTS*RA_W-1:0] wb_dest,
  input  logic [WB_PORTS*ID_W-1:0] wb_id,
  input  logic [RA_W-1:0]          rd_addr1,
  input  logic [RA_W-1:0]          rd_addr2,
  output logic [ID_W-1:0]          rd_ticket1,
  output logic [ID_W-1:0]          rd_ticket2,
  output logic                     rd_blocked1,
  output logic                     rd_blocked2
);
  logic [NUM_REGS-1:0] blocked;
  logic [NUM_REGS-1:0] wb_clr;
  logic [ID_W-1:0]     ticket [NUM_REGS];
  // registers released this cycle by a writeback carrying their current ticket
  always_comb begin
    wb_clr = '0;
    for (int k = 0; k < WB_PORTS; k++)
      if (wb_valid[k] && ticket[wb_dest[k*RA_W +: RA_W]] == wb_id[k*ID_W +: ID_W])
        wb_clr[wb_dest[k*RA_W +: RA_W]] = 1'b1;
  end
  assign rd_ticket1 = ticket[rd_addr1];
  assign rd_ticket2 = ticket[rd_addr2];
  assign rd_blocked1 = blocked[rd_addr1] & ~wb_clr[rd_addr1];
  assign rd_blocked2 = blocked[rd_addr2] & ~wb_clr[rd_addr2];
  // blocked bits: same-cycle allocation overrides a writeback clear
  always_ff @(posedge clock or posedge reset)
    if (reset) blocked <= '0;
    else blocked <= flush ? '0 : (blocked & ~wb_clr) | (alloc_en ? NUM_REGS'(1) << alloc_dest : '0);
  // tickets survive flush so late writebacks still compare against the last producer
  always_ff @(posedge clock or posedge reset)
    if (reset) for (int r = 0; r < NUM_REGS; r++) ticket[r] <= '0;
    else if (alloc_en) ticket[alloc_dest] <= alloc_id;
endmodule

// File: rtl/decode_scoreboard_dispatch.sv
// decode_scoreboard_dispatch: ROB ticket allocation, dependency resolution and one-per-cycle FU dispatch (optional SCOREBOARD_PERF_CNT_EN stall counters)
module decode_scoreboard_dispatch import decode_scoreboard_dispatch_pkg::*; #(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ROB_ENTRIES = ROB_ENTRIES_DEF,
  parameter int NUM_FU = NUM_FU_DEF,
  parameter int WB_PORTS = WB_PORTS_DEF,
  localparam int RA_W = $clog2(NUM_REGS),
  localparam int ID_W = $clog2(ROB_ENTRIES),
  localparam int FU_W = fu_width(NUM_FU)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     dec_valid,
  output logic                     dec_ready,
  input  logic [RA_W-1:0]          dec_src1,
  input  logic [RA_W-1:0]          dec_src2,
  input  logic [RA_W-1:0]          dec_dest,
  input  logic                     dec_use_src1,
  input  logic                     dec_use_src2,
  input  logic                     dec_writes_dest,
  input  logic [FU_W-1:0]          dec_fu_sel,
  output logic [NUM_FU-1:0]        disp_valid,
  input  logic [NUM_FU-1:0]        disp_ready,
  output logic [ID_W-1:0]          disp_id,
  output logic [ID_W-1:0]          disp_ticket1,
  output logic [ID_W-1:0]          disp_ticket2,
  output logic                     disp_blocked1,
  output logic                     disp_blocked2,
  input  logic [WB_PORTS-1:0]      wb_valid,
  input  logic [WB_PORTS*RA_W-1:0] wb_dest,
  input  logic [WB_PORTS*ID_W-1:0] wb_id,
  input  logic                     rob_retire,
`ifdef SCOREBOARD_PERF_CNT_EN
  output logic [31:0]              perf_stall_full,
  output logic [31:0]              perf_stall_fu,
`endif
  output logic                     rob_full
);
  logic [ID_W:0]   occ;
  logic [ID_W-1:0] tail;
  logic [ID_W-1:0] rd_ticket1, rd_ticket2;
  logic            rd_blocked1, rd_blocked2;
  logic            consumed, accept;
  assign rob_full = occ == (ID_W+1)'(ROB_ENTRIES);
  assign consumed = |(disp_valid & disp_ready);
  assign dec_ready = !flush && !rob_full && (disp_valid == '0 || consumed);
  assign accept = dec_valid && dec_ready;
  scoreboard_regtable #(.NUM_REGS(NUM_REGS), .ROB_ENTRIES(ROB_ENTRIES), .WB_PORTS(WB_PORTS)) u_regtable (
    .clock(clock), .reset(reset), .flush(flush),
    .alloc_en(accept && dec_writes_dest), .alloc_dest(dec_dest), .alloc_id(tail),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_id(wb_id),
    .rd_addr1(dec_src1), .rd_addr2(dec_src2),
    .rd_ticket1(rd_ticket1), .rd_ticket2(rd_ticket2),
    .rd_blocked1(rd_blocked1), .rd_blocked2(rd_blocked2)
  );
  // tail wraps naturally because ROB_ENTRIES is a power of two; retire on empty ROB is dropped
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      tail <= '0;
      occ <= '0;
    end else if (flush) begin
      tail <= '0;
      occ <= '0;
    end else begin
      tail <= tail + ID_W'(accept);
      occ <= occ + (ID_W+1)'(accept) - (ID_W+1)'(rob_retire && occ != '0);
    end
  // dispatch register: loads on accept, drops when consumed, otherwise holds; out-of-range sel shifts to zero
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      disp_valid <= '0;
      disp_id <= '0;
      disp_ticket1 <= '0;
      disp_ticket2 <= '0;
      disp_blocked1 <= 1'b0;
      disp_blocked2 <= 1'b0;
    end else if (flush) disp_valid <= '0;
    else if (accept) begin
      disp_valid <= NUM_FU'(1) << dec_fu_sel;
      disp_id <= tail;
      disp_ticket1 <= rd_ticket1;
      disp_ticket2 <= rd_ticket2;
      disp_blocked1 <= dec_use_src1 && rd_blocked1;
      disp_blocked2 <= dec_use_src2 && rd_blocked2;
    end else if (consumed) disp_valid <= '0;
`ifdef SCOREBOARD_PERF_CNT_EN
  // saturating stall counters, deliberately untouched by flush
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      perf_stall_full <= '0;
      perf_stall_fu <= '0;
    end else begin
      if (dec_valid && rob_full && perf_stall_full != '1) perf_stall_full <= perf_stall_full + 32'd1;
      if (dec_valid && !rob_full && !dec_ready && perf_stall_fu != '1) perf_stall_fu <= perf_stall_fu + 32'd1;
    end
`endif
endmodule

// File: doc/decode_scoreboard_dispatch.md
Name: decode_scoreboard_dispatch

Overview:
- Parametrised successor of the decode-stage register scoreboard. Allocates reorder-buffer tickets in order and tracks which architectural registers wait on an in-flight producer.
- Resolves source dependencies and dispatches one decoded instruction per cycle to one of NUM_FU functional-unit channels, for example ALU and MUL.
- Sits between the instruction decoder and the execution units. Adds ROB-occupancy back-pressure, per-channel ready handshakes and multiple writeback ports.

Parameters:
- NUM_REGS, 32, number of architectural registers tracked.
- ROB_ENTRIES, 8, reorder-buffer depth; must be a power of 2, minimum 2.
- NUM_FU, 2, number of dispatch channels.
- WB_PORTS, 1, number of writeback ports that can clear blocking per cycle.
- Derived: RA_W = $clog2(NUM_REGS), ID_W = $clog2(ROB_ENTRIES), FU_W = max(1, $clog2(NUM_FU)).

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  pipeline flush: clears the scoreboard and ROB pointers.
- dec_valid  in  1  decoded instruction is present.
- dec_ready  out  1  scoreboard accepts the instruction this cycle.
- dec_src1, dec_src2, dec_dest  in  RA_W each  register addresses.
- dec_use_src1, dec_use_src2, dec_writes_dest  in  1 each  operand and result usage flags.
- dec_fu_sel  in  FU_W  target channel.
- disp_valid  out  NUM_FU  one-hot dispatch valid.
- disp_ready  in  NUM_FU  per-channel accept.
- disp_id  out  ID_W  ROB ticket of the dispatched instruction.
- disp_ticket1, disp_ticket2  out  ID_W each  producer tickets for the sources.
- disp_blocked1, disp_blocked2  out  1 each  source still pending.
- wb_valid  in  WB_PORTS  writeback strobe.
- wb_dest  in  WB_PORTS*RA_W  writeback register addresses.
- wb_id  in  WB_PORTS*ID_W  writeback tickets.
- rob_retire  in  1  one ROB entry freed this cycle.
- rob_full  out  1  occupancy equals ROB_ENTRIES.

Behaviour:
- Reset values:
  - disp_valid = 0; tail = 0; occupancy = 0.
  - All blocked bits = 0; all ticket fields = 0.
  - Outputs reset to 0. dec_ready comes out of reset at 1.
- dec_ready = !rob_full && (disp_valid == 0 || disp_ready[current channel]).
- Accept occurs when dec_valid && dec_ready. On accept:
  - Ticket = tail.
  - tail += 1, wrapping modulo ROB_ENTRIES.
  - The output register loads on the next edge. Latency is 1 cycle from accept to disp_valid.
- Output register behaviour:
  - While disp_valid is set and disp_ready[sel] is 0, all disp_* outputs hold stable.
  - When the output is consumed with no new accept, disp_valid returns to 0.
- Source resolution, evaluated at accept:
  - disp_blockedN = use_srcN && blocked[srcN] && no wb_valid[k] this cycle whose wb_dest == srcN and wb_id == ticket[srcN].
  - disp_ticketN = ticket[srcN].
- Destination on accept with dec_writes_dest:
  - blocked[dest] = 1 and ticket[dest] = allocated id.
  - If a writeback clears the same register in the same cycle, the allocation wins.
- Writeback:
  - For each k with wb_valid[k] and ticket[wb_dest[k]] == wb_id[k], clear blocked[wb_dest[k]].
  - A stale writeback whose id does not match the current ticket is ignored.
- Occupancy:
  - occ_next = occ + accept - rob_retire.
  - Accept and retire in the same cycle leave occupancy unchanged.
  - A retire with occ == 0 is ignored.
  - rob_full = (occ == ROB_ENTRIES), so no accept is possible when full.
- Flush, which takes priority over all events:
  - At the next edge: all blocked bits = 0, tail = 0, occ = 0, disp_valid = 0.
  - Ticket fields are not cleared.
  - dec_ready is forced to 0 during the flush cycle.
- Reset asserted mid-operation: immediate return to the reset state, independent of the clock.
- If dec_fu_sel >= NUM_FU, the instruction is accepted, consumes a ticket, and dispatches nowhere (disp_valid stays 0).

Optional Feature:
- Macro: SCOREBOARD_PERF_CNT_EN.
- Defined: adds two outputs, perf_stall_full and perf_stall_fu, each 32 bits.
  - perf_stall_full increments on cycles with dec_valid && rob_full.
  - perf_stall_fu increments on cycles with dec_valid && !rob_full && !dec_ready.
  - Both counters saturate at all-ones and reset to 0. Flush does not clear them.
- Undefined: the ports and counters are absent, with no area cost.

Decomposition:
- Shared package holds:
  - Parameter defaults.
  - Typedefs rob_id_t, reg_addr_t and fu_sel_t.
  - A dispatch-request struct containing id, tickets and blocked flags.
  - FU enum constants FU_ALU = 0 and FU_MUL = 1.
- One natural sub-module: scoreboard_regtable, the blocked bits and ticket array with write and multi-port clear logic. The top level keeps the tail, occupancy and dispatch register.

Test Plan:
1. Reset, then accept dest = 5 on FU_ALU → next cycle disp_valid = 01, disp_id = 0; following accept reading src1 = 5 → disp_blocked1 = 1, disp_ticket1 = 0.
2. Writeback wb_dest = 5, wb_id = 0 in the same cycle as a src1 = 5 accept → disp_blocked1 = 0 (bypass); a later wb_id = 3 to reg 5 after re-allocation as id 1 → blocked stays 1.
3. Eight accepts with no retire → rob_full = 1, dec_ready = 0; one rob_retire → occupancy 7, next accept gets disp_id = 0 (wrap-around).
4. Hold disp_ready[1] = 0 with a MUL dispatch pending → all disp_* outputs stable for 5 cycles, dec_ready = 0; release → one transfer, then the next instruction dispatches.
5. Flush with 3 pending entries → next cycle occupancy = 0, tail = 0, disp_valid = 0, all registers read unblocked; assert reset mid-stream → outputs 0 without a clock edge.
6. SCOREBOARD_PERF_CNT_EN defined: 4 cycles of dec_valid while full → perf_stall_full = 4, perf_stall_fu = 0.
